// File: rtl/brjresolve_if.sv
// EX-stage resolve / fetch-lookup bundle for brjresolve.
// The master side is the pipeline (fetch + EX); the slave side is the resolver.
interface brjresolve_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] f_pc;
    logic             f_pred_taken;
    logic             ex_valid;
    logic             ex_stall;
    logic             ex_flush;
    logic [WIDTH-1:0] ex_pc;
    logic [7:0]       ex_op;
    logic [WIDTH-1:0] ex_rs;
    logic             ex_pred_taken;
    logic             res_valid;
    logic             res_taken;
    logic             res_mispredict;
    logic             res_jumprsel;
    logic             res_wdsel;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mispred_count;

    modport master (
        output f_pc, ex_valid, ex_stall, ex_flush, ex_pc, ex_op, ex_rs, ex_pred_taken,
        input  f_pred_taken, res_valid, res_taken, res_mispredict, res_jumprsel,
        input  res_wdsel, br_count, mispred_count
    );

    modport slave (
        input  f_pc, ex_valid, ex_stall, ex_flush, ex_pc, ex_op, ex_rs, ex_pred_taken,
        output f_pred_taken, res_valid, res_taken, res_mispredict, res_jumprsel,
        output res_wdsel, br_count, mispred_count
    );
endinterface

// File: rtl/brjresolve.sv
// Branch/jump resolver: resolves EX branches, registers result (1 cycle), flags mispredicts,
// owns a 2-bit-counter BHT for fetch; no backpressure, stall/flush simply suppress the result.
module brjresolve #(
    parameter int         WIDTH     = 16,
    parameter int         BHT_DEPTH = 16,
    parameter logic [1:0] CTR_INIT  = 2'b01,
    parameter int         CNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    brjresolve_if.slave bus
);
    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam int OP_BEQZ = 0;
    localparam int OP_BNEZ = 1;
    localparam int OP_BLTZ = 2;
    localparam int OP_BGEZ = 3;
    localparam int OP_J    = 4;
    localparam int OP_JR   = 5;
    localparam int OP_JAL  = 6;
    localparam int OP_JALR = 7;

    typedef struct packed {
        logic valid;
        logic taken;
        logic mispredict;
        logic jumprsel;
        logic wdsel;
    } res_t;

    logic [7:0]       op;
    logic             op_onehot;
    logic             live;
    logic             rs_zero;
    logic             rs_neg;
    logic             is_cond;
    logic             is_jump;
    logic             taken;
    logic             mispredict;
    res_t             res_d;
    res_t             res_q;

    logic [1:0]       bht_q [BHT_DEPTH];
    logic [IDX_W-1:0] ex_idx;
    logic [IDX_W-1:0] f_idx;
    logic             bht_upd;
    logic [1:0]       ctr_cur;
    logic [1:0]       ctr_d;

    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] br_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q;
    logic [CNT_W-1:0] mis_cnt_d;

    logic             unused_pc_bits;

    // Multi-hot opcodes are treated as not live so they can never touch state.
    always_comb begin
        op         = bus.ex_op;
        op_onehot  = (op != 8'd0) && ((op & (op - 8'd1)) == 8'd0);
        live       = bus.ex_valid & ~bus.ex_stall & ~bus.ex_flush & op_onehot;
        rs_zero    = (bus.ex_rs == '0);
        rs_neg     = bus.ex_rs[WIDTH-1];
        is_cond    = |op[OP_BGEZ:OP_BEQZ];
        is_jump    = |op[OP_JALR:OP_J];
        taken      = (op[OP_BEQZ] &  rs_zero)
                   | (op[OP_BNEZ] & ~rs_zero)
                   | (op[OP_BLTZ] &  rs_neg)
                   | (op[OP_BGEZ] & ~rs_neg)
                   | is_jump;
        mispredict = taken ^ bus.ex_pred_taken;
    end

    always_comb begin
        res_d = '0;
        if (live) begin
            res_d.valid      = 1'b1;
            res_d.taken      = taken;
            res_d.mispredict = mispredict;
            res_d.jumprsel   = op[OP_JR] | op[OP_JALR];
            res_d.wdsel      = op[OP_JAL] | op[OP_JALR];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

    // PCs are halfword aligned, so bit 0 carries no index information.
    always_comb begin
        ex_idx  = bus.ex_pc[IDX_W:1];
        f_idx   = bus.f_pc[IDX_W:1];
        bht_upd = live & is_cond;
        ctr_cur = bht_q[ex_idx];
        ctr_d   = ctr_cur;
        if (taken) begin
            if (ctr_cur != 2'b11) begin
                ctr_d = ctr_cur + 2'd1;
            end
        end else begin
            if (ctr_cur != 2'b00) begin
                ctr_d = ctr_cur - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= CTR_INIT;
            end
        end else if (bht_upd) begin
            bht_q[ex_idx] <= ctr_d;
        end
    end

    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (bht_upd && (br_cnt_q != '1)) begin
            br_cnt_d = br_cnt_q + CNT_ONE;
        end
        if (live && mispredict && (mis_cnt_q != '1)) begin
            mis_cnt_d = mis_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    // Lookup reads the stored counter directly: a same-cycle update is seen next cycle.
    assign bus.f_pred_taken   = bht_q[f_idx][1];
    assign bus.res_valid      = res_q.valid;
    assign bus.res_taken      = res_q.taken;
    assign bus.res_mispredict = res_q.mispredict;
    assign bus.res_jumprsel   = res_q.jumprsel;
    assign bus.res_wdsel      = res_q.wdsel;
    assign bus.br_count       = br_cnt_q;
    assign bus.mispred_count  = mis_cnt_q;

    assign unused_pc_bits = ^{bus.f_pc, bus.ex_pc};
endmodule

// File: tb/tb_brjresolve.sv
// Bench for brjresolve: directed scenarios plus random traffic against a behavioural model;
// a second instance with 4-bit counters exercises counter saturation.
module tb_brjresolve;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    brjresolve_if #(.WIDTH(16), .CNT_W(16)) bus16 ();
    brjresolve_if #(.WIDTH(16), .CNT_W(4))  bus4 ();

    brjresolve #(.WIDTH(16), .BHT_DEPTH(16), .CTR_INIT(2'b01), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus16.slave));
    brjresolve #(.WIDTH(16), .BHT_DEPTH(16), .CTR_INIT(2'b01), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4.slave));

    assign bus4.f_pc          = bus16.f_pc;
    assign bus4.ex_valid      = bus16.ex_valid;
    assign bus4.ex_stall      = bus16.ex_stall;
    assign bus4.ex_flush      = bus16.ex_flush;
    assign bus4.ex_pc         = bus16.ex_pc;
    assign bus4.ex_op         = bus16.ex_op;
    assign bus4.ex_rs         = bus16.ex_rs;
    assign bus4.ex_pred_taken = bus16.ex_pred_taken;

    int checks = 0;
    int failures = 0;

    // Behavioural model: counter values as plain integers 0..3, counts as integers.
    int       m_bht [16];
    int       m_br16, m_mis16, m_br4, m_mis4;
    logic [4:0] m_res;       // {valid, taken, mispredict, jumprsel, wdsel}
    logic     m_res_defined;
    logic     exp_pred;      // model prediction for f_pc during the applied cycle
    logic     obs_pred;
    logic     obs_pred4;

    function automatic logic [4:0] res16();
        return {bus16.res_valid, bus16.res_taken, bus16.res_mispredict,
                bus16.res_jumprsel, bus16.res_wdsel};
    endfunction

    function automatic logic [4:0] res4();
        return {bus4.res_valid, bus4.res_taken, bus4.res_mispredict,
                bus4.res_jumprsel, bus4.res_wdsel};
    endfunction

    function automatic logic ref_taken(input logic [7:0] op, input logic [15:0] rs);
        logic signed [15:0] srs;
        srs = rs;
        case (op)
            8'h01: return rs == 16'd0;
            8'h02: return rs != 16'd0;
            8'h04: return srs < 0;
            8'h08: return srs >= 0;
            8'h10, 8'h20, 8'h40, 8'h80: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_bht[i] = 1;
        m_br16 = 0; m_mis16 = 0; m_br4 = 0; m_mis4 = 0;
        m_res = '0;
        m_res_defined = 1'b1;
    endtask

    // Drives one EX/fetch cycle, samples the combinational prediction, advances the clock
    // and moves the model to what the registered outputs must show afterwards.
    task automatic apply(input logic v, input logic s, input logic f, input logic [15:0] pc,
                         input logic [7:0] op, input logic [15:0] rs, input logic pred,
                         input logic [15:0] fpc);
        logic live_raw, t, mis, cond;
        int idx;
        bus16.ex_valid = v; bus16.ex_stall = s; bus16.ex_flush = f;
        bus16.ex_pc = pc; bus16.ex_op = op; bus16.ex_rs = rs;
        bus16.ex_pred_taken = pred; bus16.f_pc = fpc;
        #1;
        obs_pred  = bus16.f_pred_taken;
        obs_pred4 = bus4.f_pred_taken;
        exp_pred  = (m_bht[fpc[4:1]] >= 2);
        live_raw  = v && !s && !f && (op != 8'd0);
        m_res_defined = !(live_raw && ($countones(op) != 1));
        m_res = '0;
        if (live_raw && $countones(op) == 1) begin
            t    = ref_taken(op, rs);
            mis  = (t != pred);
            cond = (op == 8'h01) || (op == 8'h02) || (op == 8'h04) || (op == 8'h08);
            m_res = {1'b1, t, mis, (op == 8'h20) || (op == 8'h80), (op == 8'h40) || (op == 8'h80)};
            if (cond) begin
                idx = pc[4:1];
                if (t) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
                else   m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
                if (m_br16 < 65535) m_br16++;
                if (m_br4 < 15) m_br4++;
            end
            if (mis) begin
                if (m_mis16 < 65535) m_mis16++;
                if (m_mis4 < 15) m_mis4++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [15:0] fpc);
        apply(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b0, fpc);
    endtask

    task automatic test_reset();
        // A live branch is pending when reset hits; it must leave no trace.
        bus16.ex_valid = 1'b1; bus16.ex_stall = 1'b0; bus16.ex_flush = 1'b0;
        bus16.ex_pc = 16'h0004; bus16.ex_op = 8'h01; bus16.ex_rs = 16'h0000;
        bus16.ex_pred_taken = 1'b0; bus16.f_pc = 16'h0000;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (res16() !== 5'b00000) begin
            failures++; $display("FAIL reset_res got=%b exp=%b", res16(), 5'b00000);
        end
        checks++;
        if (bus16.br_count !== 16'd0 || bus16.mispred_count !== 16'd0) begin
            failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", bus16.br_count, bus16.mispred_count);
        end
        checks++;
        if (bus4.br_count !== 4'd0 || bus4.mispred_count !== 4'd0) begin
            failures++; $display("FAIL reset_counts4 got=%0d/%0d exp=0/0", bus4.br_count, bus4.mispred_count);
        end
        for (int i = 0; i < 16; i++) begin
            bus16.f_pc = 16'(i * 2);
            #1;
            checks++;
            if (bus16.f_pred_taken !== 1'b0) begin
                failures++; $display("FAIL reset_pred idx=%0d got=%b exp=0", i, bus16.f_pred_taken);
            end
        end
        bus16.ex_valid = 1'b0; bus16.ex_op = 8'h00;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_beqz_taken();
        apply(1'b1, 1'b0, 1'b0, 16'h0004, 8'h01, 16'h0000, 1'b0, 16'h0004);
        checks++;
        if (obs_pred !== 1'b0) begin
            failures++; $display("FAIL beqz_old_pred got=%b exp=0", obs_pred);
        end
        checks++;
        if (res16() !== 5'b11100) begin
            failures++; $display("FAIL beqz_res got=%b exp=%b", res16(), 5'b11100);
        end
        checks++;
        if (bus16.br_count !== 16'd1 || bus16.mispred_count !== 16'd1) begin
            failures++; $display("FAIL beqz_counts got=%0d/%0d exp=1/1", bus16.br_count, bus16.mispred_count);
        end
        idle(16'h0004);
        checks++;
        if (obs_pred !== 1'b1) begin
            failures++; $display("FAIL beqz_new_pred got=%b exp=1", obs_pred);
        end
        checks++;
        if (res16() !== 5'b00000) begin
            failures++; $display("FAIL beqz_idle_res got=%b exp=%b", res16(), 5'b00000);
        end
    endtask

    task automatic test_bht_saturate();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b0, 1'b0, 16'h0006, 8'h04, 16'h8000, 1'b1, 16'h0006);
            checks++;
            if (res16() !== m_res) begin
                failures++; $display("FAIL bltz_res[%0d] got=%b exp=%b", i, res16(), m_res);
            end
        end
        apply(1'b1, 1'b0, 1'b0, 16'h0006, 8'h08, 16'h0000, 1'b1, 16'h0006);
        checks++;
        if (res16() !== 5'b11000) begin
            failures++; $display("FAIL bgez_res got=%b exp=%b", res16(), 5'b11000);
        end
        apply(1'b1, 1'b0, 1'b0, 16'h0006, 8'h02, 16'h0000, 1'b1, 16'h0006);
        checks++;
        if (res16() !== 5'b10100) begin
            failures++; $display("FAIL bnez_res got=%b exp=%b", res16(), 5'b10100);
        end
        idle(16'h0006);
        checks++;
        if (obs_pred !== 1'b1) begin
            failures++; $display("FAIL sat_after_one_dec got=%b exp=1", obs_pred);
        end
        apply(1'b1, 1'b0, 1'b0, 16'h0006, 8'h02, 16'h0000, 1'b1, 16'h0006);
        idle(16'h0006);
        checks++;
        if (obs_pred !== 1'b0) begin
            failures++; $display("FAIL sat_after_two_dec got=%b exp=0", obs_pred);
        end
        checks++;
        if (bus16.br_count !== 16'(m_br16) || bus16.mispred_count !== 16'(m_mis16)) begin
            failures++; $display("FAIL sat_counts got=%0d/%0d exp=%0d/%0d",
                                 bus16.br_count, bus16.mispred_count, m_br16, m_mis16);
        end
    endtask

    task automatic test_jalr();
        int br_before;
        br_before = m_br16;
        apply(1'b1, 1'b0, 1'b0, 16'h0004, 8'h80, 16'($urandom), 1'b1, 16'h0004);
        checks++;
        if (res16() !== 5'b11011) begin
            failures++; $display("FAIL jalr_res got=%b exp=%b", res16(), 5'b11011);
        end
        checks++;
        if (bus16.br_count !== 16'(br_before) || bus16.mispred_count !== 16'(m_mis16)) begin
            failures++; $display("FAIL jalr_counts got=%0d/%0d exp=%0d/%0d",
                                 bus16.br_count, bus16.mispred_count, br_before, m_mis16);
        end
        idle(16'h0004);
        checks++;
        if (obs_pred !== 1'b1) begin
            failures++; $display("FAIL jalr_bht_kept got=%b exp=1", obs_pred);
        end
    endtask

    task automatic test_stall_flush();
        apply(1'b1, 1'b1, 1'b0, 16'h000A, 8'h01, 16'h0000, 1'b0, 16'h000A);
        checks++;
        if (res16() !== 5'b00000) begin
            failures++; $display("FAIL stall_res got=%b exp=%b", res16(), 5'b00000);
        end
        apply(1'b1, 1'b0, 1'b1, 16'h000A, 8'h01, 16'h0000, 1'b0, 16'h000A);
        checks++;
        if (res16() !== 5'b00000) begin
            failures++; $display("FAIL flush_res got=%b exp=%b", res16(), 5'b00000);
        end
        checks++;
        if (bus16.br_count !== 16'(m_br16) || bus16.mispred_count !== 16'(m_mis16)) begin
            failures++; $display("FAIL stall_flush_counts got=%0d/%0d exp=%0d/%0d",
                                 bus16.br_count, bus16.mispred_count, m_br16, m_mis16);
        end
        apply(1'b1, 1'b0, 1'b0, 16'h000A, 8'h01, 16'h0000, 1'b0, 16'h000A);
        checks++;
        if (obs_pred !== 1'b0) begin
            failures++; $display("FAIL same_cycle_old got=%b exp=0", obs_pred);
        end
        idle(16'h000A);
        checks++;
        if (obs_pred !== 1'b1) begin
            failures++; $display("FAIL same_cycle_new got=%b exp=1", obs_pred);
        end
    endtask

    task automatic test_multihot();
        apply(1'b1, 1'b0, 1'b0, 16'h0010, 8'h03, 16'h0000, 1'b1, 16'h0010);
        idle(16'h0010);
        checks++;
        if (obs_pred !== exp_pred) begin
            failures++; $display("FAIL multihot_bht got=%b exp=%b", obs_pred, exp_pred);
        end
        checks++;
        if (bus16.br_count !== 16'(m_br16) || bus16.mispred_count !== 16'(m_mis16)) begin
            failures++; $display("FAIL multihot_counts got=%0d/%0d exp=%0d/%0d",
                                 bus16.br_count, bus16.mispred_count, m_br16, m_mis16);
        end
    endtask

    task automatic test_random();
        logic [7:0] ops [9] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        logic [15:0] rs;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0: rs = 16'h0000;
                1: rs = 16'h8000 | 16'($urandom);
                default: rs = 16'($urandom);
            endcase
            apply(($urandom_range(0, 4) != 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                  16'($urandom), ops[$urandom_range(0, 8)], rs, 1'($urandom), 16'($urandom));
            checks++;
            if (obs_pred !== exp_pred || obs_pred4 !== exp_pred) begin
                failures++; $display("FAIL rnd_pred n=%0d got=%b/%b exp=%b", n, obs_pred, obs_pred4, exp_pred);
            end
            checks++;
            if (m_res_defined && (res16() !== m_res || res4() !== m_res)) begin
                failures++; $display("FAIL rnd_res n=%0d got=%b/%b exp=%b", n, res16(), res4(), m_res);
            end
            checks++;
            if (bus16.br_count !== 16'(m_br16) || bus16.mispred_count !== 16'(m_mis16) ||
                bus4.br_count !== 4'(m_br4) || bus4.mispred_count !== 4'(m_mis4)) begin
                failures++; $display("FAIL rnd_counts n=%0d got=%0d/%0d,%0d/%0d exp=%0d/%0d,%0d/%0d", n,
                                     bus16.br_count, bus16.mispred_count, bus4.br_count, bus4.mispred_count,
                                     m_br16, m_mis16, m_br4, m_mis4);
            end
        end
    endtask

    task automatic test_cnt_saturate();
        test_reset();
        for (int i = 0; i < 20; i++) begin
            apply(1'b1, 1'b0, 1'b0, 16'(i * 2), 8'h01, 16'h0001, 1'b1, 16'h0000);
        end
        checks++;
        if (bus4.br_count !== 4'hF || bus4.mispred_count !== 4'hF) begin
            failures++; $display("FAIL cnt4_saturate got=%h/%h exp=F/F", bus4.br_count, bus4.mispred_count);
        end
        checks++;
        if (bus16.br_count !== 16'd20 || bus16.mispred_count !== 16'd20) begin
            failures++; $display("FAIL cnt16_twenty got=%0d/%0d exp=20/20", bus16.br_count, bus16.mispred_count);
        end
        apply(1'b1, 1'b0, 1'b0, 16'h0002, 8'h02, 16'h0000, 1'b1, 16'h0000);
        checks++;
        if (bus4.br_count !== 4'hF || bus4.mispred_count !== 4'hF) begin
            failures++; $display("FAIL cnt4_no_wrap got=%h/%h exp=F/F", bus4.br_count, bus4.mispred_count);
        end
    endtask

    initial begin
        bus16.ex_valid = 1'b0; bus16.ex_stall = 1'b0; bus16.ex_flush = 1'b0;
        bus16.ex_pc = '0; bus16.ex_op = '0; bus16.ex_rs = '0;
        bus16.ex_pred_taken = 1'b0; bus16.f_pc = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(16'h0000);
        test_reset();
        test_beqz_taken();
        test_bht_saturate();
        test_jalr();
        test_reset();
        test_stall_flush();
        test_multihot();
        test_random();
        test_cnt_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
